// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller that drives a one-cycle clock-enable pulse
// into the single-cycle MIPS core and counts the instructions it releases.
module cpu_run_ctrl #(
  parameter int DIV       = 50000000,
  parameter int DB_CYCLES = 500000,
  parameter int PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_sw,
  input  logic            step_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  input  logic            halt_req,
  output logic            cpu_en,
  output logic [1:0]      state,
  output logic            halted,
  output logic [15:0]     instr_cnt
);
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int DW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, lvl_q, lvl_prev_q, skip_q, skip_d, en_q, issue;
  logic [DW-1:0] db_q;
  logic [TW-1:0] tick_q;
  logic [15:0] cnt_q;
  logic step_pulse, tick, bp_hit, db_done;
  assign step_pulse = lvl_q & ~lvl_prev_q;
  assign tick = state_q == RUN && tick_q == TW'(DIV - 1);
  assign bp_hit = bp_en && pc == bp_addr && !skip_q;
  assign db_done = db_q == DW'(DB_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q <= 1'b0;
      lvl_prev_q <= 1'b0;
      db_q <= '0;
      tick_q <= '0;
      state_q <= IDLE;
      skip_q <= 1'b0;
      en_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      lvl_prev_q <= lvl_q;
      db_q <= (sync2_q == lvl_q || db_done) ? '0 : db_q + 1'b1;
      if (sync2_q != lvl_q && db_done) lvl_q <= sync2_q;
      tick_q <= (state_q != RUN || tick) ? '0 : tick_q + 1'b1;
      state_q <= state_d;
      skip_q <= skip_d;
      en_q <= issue;
      if (issue && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
    end
  // BREAK is left only by a step or by dropping run_sw; both arm skip so the
  // breakpointed instruction is released once before bp_hit can fire again.
  always_comb begin
    state_d = state_q;
    skip_d = skip_q;
    issue = 1'b0;
    if (halt_req && state_q != BRK) state_d = BRK;
    else
      case (state_q)
        IDLE: state_d = run_sw ? RUN : step_pulse ? STEP : IDLE;
        RUN:
          if (!run_sw) state_d = IDLE;
          else if (tick) begin
            if (bp_hit) state_d = BRK;
            else issue = 1'b1;
          end
        STEP: begin
          issue = 1'b1;
          state_d = IDLE;
        end
        default:
          if (step_pulse) begin
            state_d = STEP;
            skip_d = 1'b1;
          end else if (!run_sw) begin
            state_d = IDLE;
            skip_d = 1'b1;
          end
      endcase
    if (issue) skip_d = 1'b0;
  end
  assign cpu_en = en_q;
  assign state = state_q;
  assign halted = state_q == BRK;
  assign instr_cnt = cnt_q;
endmodule
